serial_sub_ctrl: RTL and testbench
==================================

# serial_sub_ctrl

Bit-serial subtraction controller for W-bit operands. It accepts an operand pair on a start/ready handshake and sequences a single 1-bit full-subtractor cell over W cycles, LSB first. The cell is built from two half-subtractor stages and an OR. Final difference and borrow are held for the consumer. It sits between a requester and the team's subtractor cells, trading area for latency.

## Interface
- `W`, default 8: operand/result width; legal range W ≥ 2.
- `clk` in, 1 bit: clock; all state updates on the rising edge.
- `rst_n` in, 1 bit: reset, asynchronous, active-low.
- `start` in, 1 bit: request; accepted only on an edge where `ready`=1.
- `a` in, W bits: minuend; sampled on the accept edge only.
- `b` in, W bits: subtrahend; sampled on the accept edge only.
- `ready` out, 1 bit: high in IDLE, otherwise low.
- `diff` out, W bits: result a−b mod 2^W; valid from the `done` cycle until the next accept.
- `borr` out, 1 bit: final borrow-out; 1 iff a < b unsigned.
- `done` out, 1 bit: one-cycle completion pulse.
- `zero` out, 1 bit: present only with `SERIAL_SUB_ZERO_EN`; 1 iff `diff`==0.

## Operation
- Internal registers:
  - operand shift registers `sa` and `sb` (W bits each);
  - result shift register `sd` (W bits);
  - borrow flop `bq`;
  - bit counter (clog2(W) bits, unsigned);
  - 2-bit state.
- States: IDLE, RUN, DONE.
- IDLE: `ready`=1. On `start`=1:
  - load `sa`←a and `sb`←b;
  - clear `bq` and the counter;
  - go to RUN.
- RUN: each edge, the cell computes from x=`sa`[0], y=`sb`[0] and bin=`bq`:
  - d = x^y^bin;
  - bout = (~x&y) | (~(x^y)&bin).
- RUN register updates on each edge:
  - `sd` ← {d, `sd`[W-1:1]};
  - `sa` and `sb` shift right by 1 (zero fill);
  - `bq` ← bout;
  - counter increments.
- RUN exit: on the edge where counter == W-1, go to DONE. `diff` and `borr` are loaded from the final `sd`/bout on that same edge.
- DONE: `done`=1 for exactly one cycle; next edge returns to IDLE.
- `start` is ignored in RUN and DONE. `a` and `b` are don't-care outside the accept edge.
- `diff` and `borr` are registered outputs:
  - they update only on the RUN→DONE edge;
  - they are held through IDLE;
  - they are not cleared by a new accept until that operation completes.
- Arithmetic: two's-complement wrap; no saturation. `borr` is the carry-out inverse of a + ~b + 1.
- Reset (`rst_n`=0), at any time including mid-RUN:
  - state←IDLE; all registers←0;
  - `ready`=1, `diff`=0, `borr`=0, `done`=0, `zero`=0 (if present), all asynchronously;
  - the in-flight operation is discarded, with no `done` pulse.
- After release, the first rising edge with `start`=1 is accepted normally.

## Timing
- Accept edge E0; bits processed on edges E1..EW.
- `done` rises after EW and falls after E(W+1). `diff`/`borr` are valid from EW onward.
- `ready` is low from E0 to E(W+1), and high again after E(W+1).
- Latency from accept to `done`: W cycles. Throughput: one operation per W+2 cycles.
- A `start` held high continuously is re-accepted at E(W+2).
- No combinational path from inputs to outputs. `ready` decodes from state only.

## Configuration
- `SERIAL_SUB_ZERO_EN` defined:
  - adds a `zero` output port;
  - `zero` is registered, updated on the RUN→DONE edge with (final `sd`==0), and reset to 0.
- Not defined: no `zero` port and no related logic; all other behaviour is identical.

## Test plan
- W=8; a=5, b=3; `start` for 1 cycle:
  - `done` is high exactly 8 cycles after accept;
  - `diff`=0x02, `borr`=0, `ready` returns 1 cycle later.
- a=3, b=5: `diff`=0xFE, `borr`=1.
- a=0xFF, b=0x01: `diff`=0xFE, `borr`=0.
- a=0, b=0: `diff`=0x00, `borr`=0. With the macro defined, also `zero`=1.
- Pulse `start` with a=9, b=9 during RUN of a=7, b=2:
  - the second request is ignored;
  - `diff`=0x05, `borr`=0;
  - only one `done` pulse occurs.
- Assert `rst_n`=0 at cycle 4 of RUN (a=0x80, b=0x01):
  - all outputs go to 0 immediately, `ready`=1, no `done`;
  - a new op, a=0x10, b=0x20, then yields `diff`=0xF0, `borr`=1.
- Hold `start`=1 continuously with fixed operands: `done` pulses every 10 cycles.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial W-bit subtractor controller: one full-subtractor cell (two half-subtractors + OR)
// iterated LSB first. Optional `zero` flag output enabled by defining SERIAL_SUB_ZERO_EN.
module serial_sub_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic [W-1:0] diff,
    output logic         borr,
    output logic         done
`ifdef SERIAL_SUB_ZERO_EN
    ,
    output logic         zero
`endif
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [W-1:0]    sa;
    logic [W-1:0]    sb;
    logic [W-1:0]    sd;
    logic            bq;
    logic [CW-1:0]   cnt;

    logic            x;
    logic            y;
    logic            hs1_d;
    logic            hs1_b;
    logic            d;
    logic            hs2_b;
    logic            bout;
    logic            last_bit;
    logic [W-1:0]    sd_next;

    // Full subtractor: first stage x-y, second stage subtracts the incoming borrow.
    assign x        = sa[0];
    assign y        = sb[0];
    assign hs1_d    = x ^ y;
    assign hs1_b    = ~x & y;
    assign d        = hs1_d ^ bq;
    assign hs2_b    = ~hs1_d & bq;
    assign bout     = hs1_b | hs2_b;
    assign sd_next  = {d, sd[W-1:1]};
    assign last_bit = (cnt == CW'(W - 1));

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sa        <= '0;
            sb        <= '0;
            sd        <= '0;
            bq        <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            borr      <= 1'b0;
`ifdef SERIAL_SUB_ZERO_EN
            zero      <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        bq  <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sd  <= sd_next;
                    sa  <= {1'b0, sa[W-1:1]};
                    sb  <= {1'b0, sb[W-1:1]};
                    bq  <= bout;
                    cnt <= cnt + CW'(1);
                    // Results are published only here, so they stay stable through IDLE and the next run.
                    if (last_bit) begin
                        diff <= sd_next;
                        borr <= bout;
`ifdef SERIAL_SUB_ZERO_EN
                        zero <= (sd_next == '0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized scoreboard bench for serial_sub_ctrl; reference model uses plain arithmetic on
// operands and cycle counts. Define SERIAL_SUB_ZERO_EN to also check the zero output.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready;
    logic [W-1:0] diff;
    logic         borr;
    logic         done;
`ifdef SERIAL_SUB_ZERO_EN
    logic         zero;
`endif

    serial_sub_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .diff  (diff),
        .borr  (borr),
        .done  (done)
`ifdef SERIAL_SUB_ZERO_EN
        ,
        .zero  (zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] ediff;
        logic         eborr;
        logic         ezero;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_until = 0;
    logic [W-1:0] held_diff = '0;
    logic         held_borr = 1'b0;
    logic         held_zero = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model of acceptance: the controller is free once W+1 edges have passed since the accept.
    always @(posedge clk) begin
        int   c_old;
        exp_t e;
        c_old = cyc;
        cyc   = c_old + 1;
        if (rst_n && start && (c_old >= busy_until)) begin
            busy_until = cyc + W + 1;
            e.ea    = a;
            e.eb    = b;
            e.ediff = W'(int'(a) - int'(b));
            e.eborr = (a < b);
            e.ezero = (a == b);
            sb_q.push_back(e);
        end
    end

    // Reset discards any in-flight operation and clears held results.
    always @(negedge rst_n) begin
        sb_q.delete();
        busy_until = 0;
        held_diff  = '0;
        held_borr  = 1'b0;
        held_zero  = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_done;
            logic exp_ready;
            exp_t e;
            exp_done  = (busy_until != 0) && (cyc == busy_until - 1);
            exp_ready = (cyc >= busy_until);
            check("done", 32'(done), 32'(exp_done));
            check("ready", 32'(ready), 32'(exp_ready));
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty at cycle %0d: got done=1 required no pending op", cyc);
                end else begin
                    e = sb_q.pop_front();
                    held_diff = e.ediff;
                    held_borr = e.eborr;
                    held_zero = e.ezero;
                    $display("txn a=0x%02h b=0x%02h -> diff=0x%02h borr=%0d (exp 0x%02h/%0d) cycle %0d",
                             e.ea, e.eb, diff, borr, e.ediff, e.eborr, cyc);
                end
            end
            check("diff", 32'(diff), 32'(held_diff));
            check("borr", 32'(borr), 32'(held_borr));
`ifdef SERIAL_SUB_ZERO_EN
            check("zero", 32'(zero), 32'(held_zero));
`endif
        end
    end

    task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob);
        @(negedge clk);
        a = oa; b = ob; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        repeat (W + 1) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(ready), 32'(1));
        check("reset_done", 32'(done), 32'(0));
        check("reset_diff", 32'(diff), 32'(0));
        check("reset_borr", 32'(borr), 32'(0));
        #2 rst_n = 1'b1;

        op(8'd5, 8'd3);
        op(8'd3, 8'd5);
        op(8'hFF, 8'h01);
        op(8'h00, 8'h00);
        op(8'h80, 8'h7F);
        op(8'h00, 8'hFF);

        // Second request during RUN must be ignored.
        @(negedge clk);
        a = 8'd7; b = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'd9; b = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // Asynchronous reset mid-run.
        @(negedge clk);
        a = 8'h80; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_done", 32'(done), 32'(0));
        check("rst_diff", 32'(diff), 32'(0));
        check("rst_borr", 32'(borr), 32'(0));
`ifdef SERIAL_SUB_ZERO_EN
        check("rst_zero", 32'(zero), 32'(0));
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        op(8'h10, 8'h20);

        // Continuous start: re-accepted every W+2 cycles.
        @(negedge clk);
        a = 8'h33; b = 8'h44; start = 1'b1;
        repeat (35) @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // Random pulses, some landing while busy.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom);
            start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, W + 3)) @(negedge clk);
        end

        repeat (W + 3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
